// File: rtl/sign_mag_combiner.sv
// sign_mag_combiner
//   Converts a vector of sign/magnitude LLRs into two's-complement LLRs. The
//   datapath is a two-stage ready/valid pipeline. Stage 1 registers the raw
//   sign/magnitude vector. Stage 2 registers the converted vector and drives
//   L directly. The block sustains one vector per cycle while out_ready is
//   high, and holds its contents stable under backpressure.
//
// Parameters
//   W   two's-complement width of one lane (magnitude is W-1 bits)
//   Wc  number of lanes per vector
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream presents signL/absL
//   in_ready   block accepts the vector this cycle
//   signL      per-lane sign, bit i = lane i, 1 = negative
//   absL       per-lane magnitude, lane i at [(i+1)*(W-1)-1 : i*(W-1)]
//   out_valid  L holds a valid converted vector
//   out_ready  downstream accepts L this cycle
//   L          per-lane two's-complement result, lane i at [(i+1)*W-1 : i*W]
//   word_cnt   number of vectors delivered, wraps at 16 bits
module sign_mag_combiner #(
  parameter int W  = 10,
  parameter int Wc = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Wc-1:0]         signL,
  input  logic [Wc*(W-1)-1:0]   absL,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Wc*W-1:0]       L,
  output logic [15:0]           word_cnt
);

  localparam int MW = W - 1;

  logic                 vld_p1;
  logic [Wc-1:0]        sign_p1;
  logic [Wc*MW-1:0]     abs_p1;

  logic                 vld_p2;
  logic [Wc*W-1:0]      l_p2;

  logic [Wc*W-1:0]      l_conv;
  logic                 accept;
  logic                 xfer;
  logic                 load_p2;

  // Zero-extending the magnitude before negation makes negative zero map to 0,
  // and the largest magnitude maps to -(2^(W-1)-1). Neither case can overflow.
  function automatic logic signed [W-1:0] sm_to_twos(input logic s,
                                                     input logic [MW-1:0] m);
    logic signed [W-1:0] ext;
    ext = $signed({1'b0, m});
    return s ? -ext : ext;
  endfunction

  // in_ready is forced high during reset. The reset branches below still
  // override whatever that handshake would have loaded.
  assign in_ready = rst || !vld_p1 || !vld_p2 || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = vld_p2 && out_ready;
  assign load_p2  = vld_p1 && (!vld_p2 || out_ready);

  assign out_valid = vld_p2;
  assign L         = l_p2;

  // ---- stage 1: capture sign/magnitude ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_p1 <= signL;
      abs_p1  <= absL;
    end
  end

  always_comb begin
    l_conv = '0;
    for (int i = 0; i < Wc; i++) begin
      l_conv[i*W +: W] = sm_to_twos(sign_p1[i], abs_p1[i*MW +: MW]);
    end
  end

  // ---- stage 2: converted output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      l_p2   <= '0;
    end else if (load_p2) begin
      vld_p2 <= 1'b1;
      l_p2   <= l_conv;
    end else if (xfer) begin
      vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= 16'h0000;
    end else if (xfer) begin
      word_cnt <= word_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_sign_mag_combiner.sv
module tb_sign_mag_combiner;

  localparam int W  = 10;
  localparam int WC = 2;
  localparam int MW = W - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [WC-1:0]       signL;
  logic [WC*MW-1:0]    absL;
  logic                out_valid;
  logic                out_ready;
  logic [WC*W-1:0]     L;
  logic [15:0]         word_cnt;

  sign_mag_combiner #(.W(W), .Wc(WC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signL(signL), .absL(absL), .out_valid(out_valid), .out_ready(out_ready),
    .L(L), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [WC*W-1:0] sb_q[$];
  logic [15:0]     exp_cnt = 16'h0000;
  logic            hold_prev = 1'b0;
  logic [WC*W-1:0] prev_L = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: each lane is the signed integer value (+/- magnitude) in W bits.
  function automatic logic [WC*W-1:0] model(input logic [WC-1:0] s,
                                            input logic [WC*MW-1:0] a);
    logic [WC*W-1:0] r;
    int mag;
    int v;
    r = '0;
    for (int i = 0; i < WC; i++) begin
      mag = int'(a[i*MW +: MW]);
      v = s[i] ? -mag : mag;
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  // Scoreboard feed: record every accepted vector and check in_ready against
  // pipeline occupancy (vectors accepted but not yet delivered).
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready},
        {31'd0, (rst || sb_q.size() < 2 || out_ready)});
    if (rst) sb_q.delete();
    else if (in_valid && in_ready) sb_q.push_back(model(signL, absL));
  end

  // Monitor: delivered vectors, counter, and hold stability under stall.
  always @(negedge clk) begin
    #1;
    chk("word_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    if (hold_prev) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_L", {12'd0, L}, {12'd0, prev_L});
    end
    hold_prev = !rst && out_valid && !out_ready;
    prev_L = L;
    if (rst) begin
      exp_cnt = 16'h0000;
    end else if (out_valid && out_ready) begin
      exp_cnt = exp_cnt + 16'h0001;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out actual=%0h required=none", L);
      end else begin
        chk("L", {12'd0, L}, {12'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    logic [MW-1:0] m;
    for (int i = 0; i < WC; i++) begin
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = '1;
        default: m = MW'($urandom);
      endcase
      absL[i*MW +: MW] = m;
      signL[i] = $urandom_range(0, 1) == 1;
    end
  endtask

  int acc;
  int vcnt;
  int n;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; signL = '0; absL = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_L", {12'd0, L}, 32'd0);
    chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
    tick();
    rst = 1'b0;

    // Basic conversion and two-cycle latency.
    in_valid = 1'b1; signL = 2'b01; absL = {9'd5, 9'd5};
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("vec1_L", {12'd0, L}, {12'd0, 10'h005, 10'h3FB});
    tick();
    @(negedge clk);
    chk("vec1_cnt", {16'd0, word_cnt}, 32'd1);

    // Max magnitude negative and negative zero.
    in_valid = 1'b1; signL = 2'b11; absL = {9'h000, 9'h1FF};
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("vec2_L", {12'd0, L}, {12'd0, 10'h000, 10'h201});
    tick();

    // Back-to-back vectors with free-flowing output.
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 4);
      rand_vec();
      @(negedge clk);
      if (out_valid) vcnt++;
      tick();
    end
    chk("b2b_valid_cycles", vcnt, 4);
    @(negedge clk);
    chk("b2b_cnt", {16'd0, word_cnt}, 32'd6);

    // Stall: only two vectors fit, then in_ready drops.
    tick();
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int k = 0; k < 5; k++) begin
      rand_vec();
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
    end
    chk("stall_accepts", acc, 2);
    @(negedge clk);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("stall_drained", sb_q.size(), 0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_vec();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", sb_q.size(), 0);

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin rand_vec(); tick(); end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_L", {12'd0, L}, 32'd0);
    chk("rst2_cnt", {16'd0, word_cnt}, 32'd0);
    in_valid = 1'b1; rand_vec();
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_lat_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("rst2_lat_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Counter wrap.
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (exp_cnt != 16'hFFFF && n < 70000) begin
      rand_vec();
      tick();
      n++;
    end
    chk("wrap_reach", {16'd0, exp_cnt}, 32'h0000FFFF);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("cnt_ffff", {16'd0, word_cnt}, 32'h0000FFFF);
    chk("wrap_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("cnt_wrap", {16'd0, word_cnt}, 32'd0);
    repeat (4) tick();
    chk("final_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
